// File: rtl/rgb_to_palette_index_pkg.sv
// Shared definitions for the RGB-to-palette quantizer.
// Contents: channel/index/distance widths, the controller state enum and the
// power-on palette that the table reloads on reset.
package rgb_to_palette_index_pkg;

  localparam int unsigned CH_W      = 4;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned DIST_W    = 6;
  localparam int unsigned RGB_W     = 3 * CH_W;
  localparam int unsigned N_ENTRIES = 1 << IDX_W;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StDone
  } state_e;

  // Entry 0 is listed first.
  localparam logic [RGB_W-1:0] DEFAULT_PALETTE [N_ENTRIES] = '{
    12'hE5F, 12'h3DD, 12'hF0F, 12'hCED,
    12'hC43, 12'h875, 12'h1D5, 12'hFFF,
    12'h6A9, 12'h9EB, 12'hE33, 12'h2A5,
    12'h5C8, 12'h2C6, 12'h2C6, 12'hAAA
  };

endpackage

// File: rtl/rgb_manhattan_dist.sv
// Combinational Manhattan distance between two packed {r,g,b} colours.
// Ports:
//   a_i    - first colour, {r,g,b} at CH_W bits each
//   b_i    - second colour, same packing
//   dist_o - |dr| + |dg| + |db| (at most 45 for 4-bit channels)
module rgb_manhattan_dist
  import rgb_to_palette_index_pkg::*;
(
  input  logic [RGB_W-1:0]  a_i,
  input  logic [RGB_W-1:0]  b_i,
  output logic [DIST_W-1:0] dist_o
);

  function automatic logic [CH_W-1:0] abs_diff(input logic [CH_W-1:0] x,
                                                input logic [CH_W-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  logic [CH_W-1:0] d_r, d_g, d_b;

  always_comb begin
    d_r    = abs_diff(a_i[2*CH_W +: CH_W], b_i[2*CH_W +: CH_W]);
    d_g    = abs_diff(a_i[CH_W +: CH_W],   b_i[CH_W +: CH_W]);
    d_b    = abs_diff(a_i[0 +: CH_W],      b_i[0 +: CH_W]);
    dist_o = DIST_W'(d_r) + DIST_W'(d_g) + DIST_W'(d_b);
  end

endmodule

// File: rtl/rgb_to_palette_index.sv
// Nearest-colour palette quantizer.
// Accepts one 12-bit pixel in IDLE, scans the 16-entry palette one entry per
// cycle (SEARCH), then presents the lowest-index nearest entry and its
// Manhattan distance in DONE until the consumer takes it.
// Ports:
//   Clk, Reset_n         - clock, asynchronous active-low reset
//   in_valid/in_ready    - pixel handshake, in_rgb = {r,g,b}
//   out_valid/out_ready  - result handshake, out_index / out_dist
//   pal_we/addr/data     - palette write port (rejected while searching)
//   pal_wr_err           - one-cycle pulse after a rejected write
module rgb_to_palette_index
  import rgb_to_palette_index_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RGB_W-1:0]  in_rgb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [DIST_W-1:0] out_dist,
  input  logic              pal_we,
  input  logic [IDX_W-1:0]  pal_addr,
  input  logic [RGB_W-1:0]  pal_data,
  output logic              pal_wr_err
);

  localparam logic [IDX_W-1:0] LastIdx = '1;

  state_e             state_q, state_d;
  logic [RGB_W-1:0]   pal_q [N_ENTRIES];
  logic [RGB_W-1:0]   pix_q, pix_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [DIST_W-1:0]  best_dist_q, best_dist_d;
  logic [IDX_W-1:0]   out_index_q, out_index_d;
  logic [DIST_W-1:0]  out_dist_q, out_dist_d;
  logic               pal_wr_err_q, pal_wr_err_d;
  logic [DIST_W-1:0]  cand_dist;
  logic               pal_write;

  rgb_manhattan_dist u_dist (
    .a_i    (pix_q),
    .b_i    (pal_q[idx_q]),
    .dist_o (cand_dist)
  );

  assign pal_write = pal_we && (state_q != StSearch);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(N_ENTRIES); i++) begin
        pal_q[i] <= DEFAULT_PALETTE[i];
      end
    end else if (pal_write) begin
      pal_q[pal_addr] <= pal_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    pix_d        = pix_q;
    idx_d        = idx_q;
    best_idx_d   = best_idx_q;
    best_dist_d  = best_dist_q;
    out_index_d  = out_index_q;
    out_dist_d   = out_dist_q;
    pal_wr_err_d = pal_we && (state_q == StSearch);

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          pix_d       = in_rgb;
          idx_d       = '0;
          best_idx_d  = '0;
          best_dist_d = '1;
          state_d     = StSearch;
        end
      end
      StSearch: begin
        // Strictly smaller only, so ties keep the lower index.
        if (cand_dist < best_dist_q) begin
          best_idx_d  = idx_q;
          best_dist_d = cand_dist;
        end
        idx_d = idx_q + 1'b1;
        if ((idx_q == LastIdx) || (EARLY_EXIT && (cand_dist == '0))) begin
          out_index_d = best_idx_d;
          out_dist_d  = best_dist_d;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= StIdle;
      pix_q        <= '0;
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_dist_q  <= '1;
      out_index_q  <= '0;
      out_dist_q   <= '0;
      pal_wr_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      idx_q        <= idx_d;
      best_idx_q   <= best_idx_d;
      best_dist_q  <= best_dist_d;
      out_index_q  <= out_index_d;
      out_dist_q   <= out_dist_d;
      pal_wr_err_q <= pal_wr_err_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign out_index  = out_index_q;
  assign out_dist   = out_dist_q;
  assign pal_wr_err = pal_wr_err_q;

endmodule

// File: tb/tb_rgb_to_palette_index.sv
// Directed bench for rgb_to_palette_index (EARLY_EXIT = 1).
module tb_rgb_to_palette_index;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_rgb = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_index;
  logic [5:0]  out_dist;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_addr = '0;
  logic [11:0] pal_data = '0;
  logic        pal_wr_err;

  int vectors = 0;
  int errors  = 0;

  rgb_to_palette_index #(.EARLY_EXIT(1'b1)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rgb     (in_rgb),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_dist   (out_dist),
    .pal_we     (pal_we),
    .pal_addr   (pal_addr),
    .pal_data   (pal_data),
    .pal_wr_err (pal_wr_err)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Present a pixel for one edge, then count edges until out_valid (bounded).
  task automatic run_pixel(input logic [11:0] rgb, output int lat);
    in_valid = 1'b1;
    in_rgb   = rgb;
    step();
    in_valid = 1'b0;
    pal_we   = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_index !== 4'd0 ||
        out_dist !== 6'd0 || pal_wr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b idx=%0d dist=%0d err=%b, want 1 0 0 0 0",
               in_ready, out_valid, out_index, out_dist, pal_wr_err);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_early_exit();
    int lat;
    run_pixel(12'hF0F, lat);
    vectors++;
    if (lat !== 3 || out_index !== 4'd2 || out_dist !== 6'd0) begin
      errors++;
      $display("FAIL early_exit: lat=%0d idx=%0d dist=%0d, want 3 2 0", lat, out_index, out_dist);
    end
    consume();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL handshake_return: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_tie();
    int lat;
    run_pixel(12'h2C6, lat);
    vectors++;
    if (lat !== 14 || out_index !== 4'd13 || out_dist !== 6'd0) begin
      errors++;
      $display("FAIL tie_low_index: lat=%0d idx=%0d dist=%0d, want 14 13 0",
               lat, out_index, out_dist);
    end
    consume();
  endtask

  task automatic test_full_search();
    int lat;
    run_pixel(12'h000, lat);
    vectors++;
    if (lat !== 16 || out_index !== 4'd11 || out_dist !== 6'd17) begin
      errors++;
      $display("FAIL full_search: lat=%0d idx=%0d dist=%0d, want 16 11 17",
               lat, out_index, out_dist);
    end
    consume();
  endtask

  task automatic test_done_hold();
    int lat;
    run_pixel(12'h000, lat);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        in_valid = 1'b1;
        in_rgb   = 12'hF0F;
      end else begin
        in_valid = 1'b0;
      end
      step();
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_index !== 4'd11 ||
          out_dist !== 6'd17) begin
        errors++;
        $display("FAIL done_hold[%0d]: vld=%b rdy=%b idx=%0d dist=%0d, want 1 0 11 17",
                 c, out_valid, in_ready, out_index, out_dist);
      end
    end
    in_valid = 1'b0;
    consume();
    step();
    step();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ignored_pulse: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_pal_write_search();
    int lat;
    in_valid = 1'b1;
    in_rgb   = 12'h000;
    step();
    in_valid = 1'b0;
    step();
    pal_we   = 1'b1;
    pal_addr = 4'd11;
    pal_data = 12'h000;
    step();
    pal_we = 1'b0;
    vectors++;
    if (pal_wr_err !== 1'b1) begin
      errors++;
      $display("FAIL wr_err_pulse: err=%b, want 1", pal_wr_err);
    end
    step();
    vectors++;
    if (pal_wr_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_err_single: err=%b, want 0", pal_wr_err);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    vectors++;
    if (out_valid !== 1'b1 || out_index !== 4'd11 || out_dist !== 6'd17) begin
      errors++;
      $display("FAIL rejected_write: vld=%b idx=%0d dist=%0d, want 1 11 17",
               out_valid, out_index, out_dist);
    end
    consume();
  endtask

  task automatic test_pal_write_idle();
    int lat;
    pal_we   = 1'b1;
    pal_addr = 4'd0;
    pal_data = 12'h000;
    step();
    pal_we = 1'b0;
    vectors++;
    if (pal_wr_err !== 1'b0) begin
      errors++;
      $display("FAIL idle_write_err: err=%b, want 0", pal_wr_err);
    end
    run_pixel(12'h000, lat);
    vectors++;
    if (lat !== 1 || out_index !== 4'd0 || out_dist !== 6'd0) begin
      errors++;
      $display("FAIL idle_write: lat=%0d idx=%0d dist=%0d, want 1 0 0", lat, out_index, out_dist);
    end
    consume();
  endtask

  task automatic test_simultaneous();
    int lat;
    // Entry 0 (000 from previous test) becomes FFF in the same edge as accept.
    pal_we   = 1'b1;
    pal_addr = 4'd0;
    pal_data = 12'hFFF;
    run_pixel(12'h000, lat);
    vectors++;
    if (lat !== 16 || out_index !== 4'd11 || out_dist !== 6'd17) begin
      errors++;
      $display("FAIL write_with_accept: lat=%0d idx=%0d dist=%0d, want 16 11 17",
               lat, out_index, out_dist);
    end
    consume();
  endtask

  task automatic test_reset_mid_search();
    int lat;
    in_valid = 1'b1;
    in_rgb   = 12'h000;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) step();
    #2;
    Reset_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_output[%0d]: vld=%b, want 0", c, out_valid);
      end
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    // Entry 0 is back to E5F only if the table was restored.
    run_pixel(12'hE5F, lat);
    vectors++;
    if (lat !== 1 || out_index !== 4'd0 || out_dist !== 6'd0) begin
      errors++;
      $display("FAIL table_restored: lat=%0d idx=%0d dist=%0d, want 1 0 0",
               lat, out_index, out_dist);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_early_exit();
    test_tie();
    test_full_search();
    test_done_hold();
    test_pal_write_search();
    test_pal_write_idle();
    test_simultaneous();
    test_reset_mid_search();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rgb_to_palette_index.md
RGB_TO_PALETTE_INDEX -- requirements
Module: rgb_to_palette_index

Interface
REQ-001 SHALL have parameter EARLY_EXIT, default 1, meaning the search stops on the first zero-distance entry when 1.
REQ-002 SHALL have port Clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, meaning in_rgb holds a pixel to quantize.
REQ-005 SHALL have port in_ready, output, 1, meaning a pixel is accepted this cycle if in_valid is high.
REQ-006 SHALL have port in_rgb, input, 12, packed {red, green, blue} at 4 bits each.
REQ-007 SHALL have port out_valid, output, 1, meaning the result is available.
REQ-008 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-009 SHALL have port out_index, output, 4, the nearest palette index.
REQ-010 SHALL have port out_dist, output, 6, the winning distance.
REQ-011 SHALL have port pal_we, input, 1, palette table write enable.
REQ-012 SHALL have port pal_addr, input, 4, the palette entry to write.
REQ-013 SHALL have port pal_data, input, 12, the {r,g,b} value to write.
REQ-014 SHALL have port pal_wr_err, output, 1, a one-cycle pulse when a write is rejected.

Function
REQ-015 SHALL implement FSM states IDLE, SEARCH and DONE; in_ready is high only in IDLE, and out_valid is high only in DONE.
REQ-016 SHALL, in IDLE with in_valid high, capture in_rgb, clear the search index to 0, set the best distance to 63 and enter SEARCH.
REQ-017 SHALL, in SEARCH, compare exactly one entry per cycle using distance |dr|+|dg|+|db| (unsigned, 6 bits, maximum 45).
REQ-018 SHALL replace the best result only on a strictly smaller distance, so ties resolve to the lowest index.
REQ-019 SHALL enter DONE after comparing entry 15, or, when EARLY_EXIT=1, after comparing an entry with distance 0.
REQ-020 SHALL meet this latency: with acceptance at edge E0, out_valid rises after edge E(k+1), where k is the last entry compared; full search takes 16 cycles.
REQ-021 SHALL, in DONE, hold out_index and out_dist stable until out_valid and out_ready are both high, then return to IDLE; there is no accept in the same cycle.
REQ-022 SHALL keep out_index and out_dist valid only while out_valid is high; their values are held otherwise.
REQ-023 SHALL, on pal_we in IDLE or DONE, write pal_data to entry pal_addr, with the new value used by any search starting afterwards.
REQ-024 SHALL, on pal_we in SEARCH, leave the table unchanged and pulse pal_wr_err high for one cycle.
REQ-025 SHALL give a simultaneous pal_we and in_valid accept in IDLE the following behaviour: the write completes, and the search starting next cycle uses the new value.

Reset
REQ-026 SHALL, on Reset_n low, immediately force state IDLE, in_ready 1, out_valid 0, out_index 0, out_dist 0 and pal_wr_err 0.
REQ-027 SHALL, on Reset_n low, load the palette table with DEFAULT_PALETTE.
REQ-028 SHALL, on Reset_n assertion mid-search, discard the search and emit no output.
REQ-029 SHALL, after reset release, accept a pixel on the first edge at which in_valid is high.

Structure
REQ-030 SHALL place in a shared package: DEFAULT_PALETTE (16x12-bit), the state enum, and the widths CH_W=4, IDX_W=4, DIST_W=6.
REQ-031 SHALL use DEFAULT_PALETTE entries 0=E5F, 1=3DD, 2=F0F, 3=CED, 4=C43, 5=875, 6=1D5, 7=FFF, 8=6A9, 9=9EB, 10=E33, 11=2A5, 12=5C8, 13=2C6, 14=2C6, 15=AAA.
REQ-032 SHALL factor the distance computation into one combinational sub-module, rgb_manhattan_dist.

Verification
REQ-033 SHALL cover: after reset, pixel F0F -> out_index 2, out_dist 0, out_valid rising 3 edges after accept (EARLY_EXIT=1).
REQ-034 SHALL cover: pixel 2C6 -> out_index 13 (tie with entry 14), dist 0; pixel 000 -> index 11, dist 17, after a 16-cycle search.
REQ-035 SHALL cover: out_ready held low 10 cycles in DONE -> out_index/out_dist stable, in_ready low, and a pulsed in_valid ignored.
REQ-036 SHALL cover: pal_we during SEARCH -> pal_wr_err pulse and unchanged result; pal_we addr 0=000 in IDLE, then pixel 000 -> index 0, dist 0.
REQ-037 SHALL cover: Reset_n low at search cycle 5 -> out_valid stays 0, in_ready 1 immediately, and the table restored to default.
